// File: rtl/calc_pkg.sv
// Shared opcode constants, FSM encoding and helpers for the
// two-requester calculator arbiter.
package calc_pkg;

    localparam int OPW = 4;
    localparam int RW  = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_divide(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational 4-bit unsigned ALU producing an 8-bit result
// and an error flag for illegal opcodes or division by zero.
module calc_alu
    import calc_pkg::*;
#(
    parameter logic [7:0] ZERO_DIV_RESULT = 8'h00
) (
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic [2:0]     op,
    output logic [RW-1:0]  data,
    output logic           err
);

    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic [OPW-1:0] bsafe;

    assign ax = {4'b0000, a};
    assign bx = {4'b0000, b};
    // keep the divider free of a zero divisor; result is replaced anyway
    assign bsafe = (b == '0) ? 4'd1 : b;

    always_comb begin
        data = '0;
        err  = 1'b0;
        if (is_divide(op) && b == '0) begin
            data = ZERO_DIV_RESULT;
            err  = 1'b1;
        end else begin
            case (op)
                OP_ADD: data = ax + bx;
                OP_SUB: data = ax - bx;
                OP_MUL: data = ax * bx;
                OP_DIV: data = {4'b0000, a / bsafe};
                OP_MOD: data = {4'b0000, a % bsafe};
                default: begin
                    data = '0;
                    err  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter feeding two requesters into one shared
// calculator, with an IDLE/EXEC/RESP pipeline and held response.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter logic [7:0] ZERO_DIV_RESULT = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    input  logic [2:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    input  logic [2:0]     req1_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [RW-1:0]  rsp_data,
    output logic           rsp_id,
    output logic           rsp_err
);

    state_t         state;
    logic           rr;
    logic           gnt;
    logic           hs;
    logic [OPW-1:0] a_q;
    logic [OPW-1:0] b_q;
    logic [2:0]     op_q;
    logic           id_q;
    logic [RW-1:0]  alu_data;
    logic           alu_err;

    // contention goes to rr, otherwise whoever is asking
    always_comb begin
        if (req0_valid && req1_valid) gnt = rr;
        else                          gnt = req1_valid;
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !gnt;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && gnt;
    assign hs = req0_ready || req1_ready;

    calc_alu #(
        .ZERO_DIV_RESULT(ZERO_DIV_RESULT)
    ) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .data(alu_data),
        .err (alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        a_q   <= gnt ? req1_a  : req0_a;
                        b_q   <= gnt ? req1_b  : req0_b;
                        op_q  <= gnt ? req1_op : req0_op;
                        id_q  <= gnt;
                        rr    <= ~gnt;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_data;
                    rsp_err   <= alu_err;
                    rsp_id    <= id_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed scenarios plus
// randomized traffic checked against an arithmetic reference model.
module tb_calc_arbiter;

    localparam logic [7:0] ZDR = 8'hA5;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id, rsp_err;

    int n_checks;
    int n_fail;

    calc_arbiter #(.ZERO_DIV_RESULT(ZDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op,
                                  output logic [7:0] d, output logic e);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        d = 8'h00;
        e = 1'b0;
        case (int'(op))
            0: d = 8'(ia + ib);
            1: d = 8'(ia - ib);
            2: d = 8'(ia * ib);
            3: if (ib == 0) begin d = ZDR; e = 1'b1; end else d = 8'(ia / ib);
            4: if (ib == 0) begin d = ZDR; e = 1'b1; end else d = 8'(ia % ib);
            default: begin d = 8'h00; e = 1'b1; end
        endcase
    endfunction

    task automatic drive(input bit id, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_one(input bit id, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, output logic [7:0] d,
                           output logic rid, output logic e, output int lat,
                           output bit ok);
        int n;
        ok = 1'b0; lat = 0; d = '0; rid = 1'b0; e = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(id, 1'b1, a, b, op);
        n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            drive(id, 1'b0, a, b, op);
            return;
        end
        @(negedge clk);
        drive(id, 1'b0, a, b, op);
        lat = 1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); lat++; n++;
        end
        if (!rsp_valid) return;
        d = rsp_data; rid = rsp_id; e = rsp_err; ok = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_rsp got v=%b d=%h id=%b e=%b want all 0",
                     rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] d; logic rid, e; int lat; bit ok;
        do_reset();
        run_one(1'b0, 4'd7, 4'd9, 3'b000, d, rid, e, lat, ok);
        n_checks++;
        if (!ok || d !== 8'd16 || rid !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL single got ok=%0b d=%0d id=%b e=%b want d=16 id=0 e=0", ok, d, rid, e);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL single_latency got=%0d want=2", lat);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_release got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [7:0] q_d[$];
        logic       q_e[$];
        logic       q_id[$];
        logic [7:0] d; logic e;
        bit g, chg0;
        int grants;
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 4'd15, 4'd15, 3'b010);
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 4)));
        g = 1'b0;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chg0 = 1'b0;
            if (req0_ready && req1_ready) begin
                n_checks++; n_fail++;
                $display("FAIL contention_two_ready cycle=%0d", i);
            end else if (req0_ready || req1_ready) begin
                n_checks++;
                if (req1_ready !== g) begin
                    n_fail++; $display("FAIL contention_grant got=%b want=%b", req1_ready, g);
                end
                if (req1_ready) model(req1_a, req1_b, req1_op, d, e);
                else            model(req0_a, req0_b, req0_op, d, e);
                q_d.push_back(d); q_e.push_back(e); q_id.push_back(req1_ready);
                chg0 = req0_ready;
                g = ~g;
                grants++;
            end
            if (rsp_valid) begin
                n_checks++;
                if (q_d.size() == 0) begin
                    n_fail++; $display("FAIL contention_spurious_rsp d=%h", rsp_data);
                end else begin
                    d = q_d.pop_front(); e = q_e.pop_front(); g = g;
                    if (rsp_data !== d || rsp_err !== e || rsp_id !== q_id[0]) begin
                        n_fail++;
                        $display("FAIL contention_rsp got d=%h e=%b id=%b want d=%h e=%b id=%b",
                                 rsp_data, rsp_err, rsp_id, d, e, q_id[0]);
                    end
                    void'(q_id.pop_front());
                end
            end
            @(negedge clk);
            if (chg0)
                drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)));
        end
        n_checks++;
        if (grants < 4) begin
            n_fail++; $display("FAIL contention_grant_count got=%0d want>=4", grants);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic e;
        logic [7:0] d0; logic e0;
        int n;
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
        model(req1_a, req1_b, req1_op, d, e);
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_grant got=%b want=1", req1_ready);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
              3'($urandom_range(0, 4)));
        drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'b000);
        model(req0_a, req0_b, req0_op, d0, e0);
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e || rsp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b id=%b rdy=%b%b want v=1 d=%h e=%b id=1 rdy=00",
                         i, rsp_valid, rsp_data, rsp_err, rsp_id, req0_ready, req1_ready, d, e);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_after got v=%b rdy=%b%b want v=0 rdy=10",
                     rsp_valid, req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_err !== e0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stalled_req got v=%b d=%h e=%b id=%b want v=1 d=%h e=%b id=0",
                     rsp_valid, rsp_data, rsp_err, rsp_id, d0, e0);
        end
    endtask

    task automatic test_errors();
        logic [3:0] ta[6] = '{4'd9, 4'd4, 4'd3, 4'd5, 4'd7, 4'd15};
        logic [3:0] tb[6] = '{4'd0, 4'd2, 4'd5, 4'd0, 4'd3, 4'd15};
        logic [2:0] to[6] = '{3'b011, 3'b110, 3'b001, 3'b100, 3'b101, 3'b111};
        logic [7:0] d, ed; logic rid, e, ee; int lat; bit ok;
        for (int i = 0; i < 6; i++) begin
            model(ta[i], tb[i], to[i], ed, ee);
            run_one(1'b0, ta[i], tb[i], to[i], d, rid, e, lat, ok);
            n_checks++;
            if (!ok || d !== ed || e !== ee || rid !== 1'b0) begin
                n_fail++;
                $display("FAIL errors_%0d got ok=%0b d=%h e=%b id=%b want d=%h e=%b id=0",
                         i, ok, d, e, rid, ed, ee);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b; logic [2:0] op; bit id;
        logic [7:0] d, ed; logic rid, e, ee; int lat; bit ok;
        for (int i = 0; i < 24; i++) begin
            id = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            op = 3'($urandom_range(0, 7));
            model(a, b, op, ed, ee);
            run_one(id, a, b, op, d, rid, e, lat, ok);
            n_checks++;
            if (!ok || d !== ed || e !== ee || rid !== id || lat !== 2) begin
                n_fail++;
                $display("FAIL random_%0d a=%0d b=%0d op=%0d got ok=%0b d=%h e=%b id=%b lat=%0d want d=%h e=%b id=%b lat=2",
                         i, a, b, op, ok, d, e, rid, lat, ed, ee, id);
            end
        end
    endtask

    task automatic test_reset_exec();
        logic [7:0] d; logic rid, e; int lat; bit ok;
        do_reset();
        run_one(1'b0, 4'd1, 4'd2, 3'b000, d, rid, e, lat, ok);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd3, 4'd4, 3'b010);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_exec_grant got=%b want=1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_exec_no_rsp cyc=%0d got=%b want=0", i, rsp_valid);
            end
        end
        drive(1'b0, 1'b1, 4'd2, 4'd2, 3'b000);
        drive(1'b1, 1'b1, 4'd5, 4'd5, 3'b000);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_exec_rr got=%b%b want=10", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'd4 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_next got v=%b d=%h id=%b want v=1 d=04 id=0",
                     rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 3'd0);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_errors();
        test_random();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter ZERO_DIV_RESULT, default 8'h00: data returned for divide or modulo by zero.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  4 each  requester 0 unsigned operands.
REQ-007 req0_op  in  3  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_data  out  8  result.
REQ-012 rsp_id  out  1  index of requester that issued the result.
REQ-013 rsp_err  out  1  illegal opcode, or divide/modulo by zero.

Function
REQ-014 The block SHALL have FSM states IDLE, EXEC and RESP.
- IDLE -> EXEC on handshake.
- EXEC -> RESP unconditionally after one cycle.
- RESP -> IDLE on rsp_valid && rsp_ready.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready per cycle.
REQ-016 Grant in IDLE:
- Only one valid: that requester.
- Both valid: requester selected by round-robin pointer rr.
REQ-017 On handshake, operands, opcode and requester index SHALL be registered and rr SHALL be set to the other requester.
REQ-018 In EXEC, the registered result SHALL be produced from the opcode:
- 000: a+b.
- 001: a-b as 8-bit two's complement of zero-extended operands.
- 010: a*b.
- 011: a/b.
- 100: a%b.
REQ-019 Widths: results SHALL be zero-extended to 8 bits with no truncation (max sum 30, max product 225).
REQ-020 Opcodes 101-111 SHALL give rsp_data 8'h00 and rsp_err 1.
REQ-021 Opcode 011 or 100 with b==0 SHALL give rsp_data ZERO_DIV_RESULT and rsp_err 1; otherwise rsp_err 0.
REQ-022 rsp_valid SHALL be high exactly in RESP; rsp_data, rsp_id and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 Latency: handshake at edge N gives rsp_valid high in the cycle after edge N+1. Minimum issue interval is 3 cycles.
REQ-024 Requests arriving during EXEC or RESP SHALL stall (ready low) and are not lost; the requester holds its valid.
REQ-025 A requester dropping valid before ready SHALL cause no state change.

Reset
REQ-026 When rst is high at a clock edge, the block SHALL enter IDLE and set rr=0.
REQ-027 Reset values: reqN_ready 0 during the reset cycle, rsp_valid 0, rsp_data 8'h00, rsp_id 0, rsp_err 0.
REQ-028 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-029 Opcode constants (OP_ADD..OP_MOD) and the FSM state encoding SHALL live in a shared package calc_pkg.
REQ-030 Arithmetic SHALL be one combinational sub-module calc_alu (a, b, op -> data, err), instantiated once and shared by both requesters.

Verification
REQ-031 Single request: req0 a=7, b=9, op=000 -> rsp_data 16, rsp_id 0, rsp_err 0, rsp_valid two cycles after handshake.
REQ-032 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; req1 op=010, a=15, b=15 -> 225.
REQ-033 Back-pressure: rsp_ready held low 5 cycles -> rsp_valid and data stable; both reqN_ready stay 0 throughout.
REQ-034 Errors:
- op=011, a=9, b=0 -> rsp_err 1, data ZERO_DIV_RESULT.
- op=110 -> rsp_err 1, data 0.
- op=001, a=3, b=5 -> 8'hFE, rsp_err 0.
REQ-035 Reset in EXEC -> no rsp_valid follows; next request from req0 is granted first (rr=0).
